// File: rtl/im_debug_sequencer.sv
// Debug sequencer: loads a program from a UART byte stream into instruction
// memory, then runs or single-steps the pipeline until it reports a halt.
module im_debug_sequencer #(
  parameter int             LEN       = 32,
  parameter int             ADDR_W    = 11,
  parameter logic [7:0]     CMD_LOAD  = 8'h4C,
  parameter logic [7:0]     CMD_RUN   = 8'h52,
  parameter logic [7:0]     CMD_STEP  = 8'h53,
  parameter logic [7:0]     CMD_NEXT  = 8'h4E,
  parameter logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_halt,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [LEN-1:0]    o_im_data,
  output logic              o_pipe_en,
  output logic              o_pipe_rst,
  output logic              o_loaded,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic [LEN-1:0]    o_cycle_cnt,
  output logic [2:0]        o_dbg_state
);

  localparam int BYTES = LEN / 8;
  localparam int BC_W  = $clog2(BYTES);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_WRITE    = 3'd2,
    S_PIPE_RST = 3'd3,
    S_RUN      = 3'd4,
    S_STEP     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [LEN-1:0]    word_q, word_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_step_q, mode_step_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [LEN-1:0]    im_data_q, im_data_d;
  logic              pipe_en_q, pipe_en_d;
  logic              pipe_rst_q, pipe_rst_d;
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [LEN-1:0]    cycle_cnt_q, cycle_cnt_d;

  logic [LEN-1:0]    word_shift;
  logic              is_run_or_step;

  // i_rx_valid is a one-cycle strobe with no ready: every strobed byte is
  // either consumed in the cycle it arrives or ignored, never back-pressured.
  assign word_shift     = {word_q[LEN-9:0], i_rx_data};
  assign is_run_or_step = (i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP);

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    mode_step_d = mode_step_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_data_d   = im_data_q;
    pipe_en_d   = 1'b0;
    pipe_rst_d  = 1'b1;
    loaded_d    = loaded_q;
    done_d      = done_q;
    word_cnt_d  = word_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_rx_valid && i_rx_data == CMD_LOAD) begin
          state_d    = S_LOAD;
          addr_d     = '0;
          byte_cnt_d = '0;
          loaded_d   = 1'b0;
        end else if (i_rx_valid && is_run_or_step && loaded_q) begin
          state_d     = S_PIPE_RST;
          mode_step_d = (i_rx_data == CMD_STEP);
          pipe_rst_d  = 1'b0;
          cycle_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (i_rx_valid) begin
          word_d     = word_shift;
          byte_cnt_d = byte_cnt_q + BC_W'(1);
          // The write strobe is launched here so it appears one cycle after the last byte.
          if (byte_cnt_q == LAST_BYTE) begin
            state_d   = S_WRITE;
            im_we_d   = 1'b1;
            im_addr_d = addr_q;
            im_data_d = word_shift;
          end
        end
      end
      S_WRITE: begin
        byte_cnt_d = '0;
        addr_d     = addr_q + ADDR_W'(1);
        word_cnt_d = {1'b0, addr_q} + (ADDR_W + 1)'(1);
        if (word_q == HALT_WORD || addr_q == '1) begin
          state_d  = S_IDLE;
          loaded_d = 1'b1;
        end else begin
          state_d = S_LOAD;
          // A byte arriving now already belongs to the next word.
          if (i_rx_valid) begin
            word_d     = word_shift;
            byte_cnt_d = BC_W'(1);
          end
        end
      end
      S_PIPE_RST: begin
        state_d   = mode_step_q ? S_STEP : S_RUN;
        pipe_en_d = !mode_step_q;
      end
      S_RUN: begin
        if (i_halt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          pipe_en_d = 1'b1;
        end
      end
      S_STEP: begin
        if (i_halt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (i_rx_valid && i_rx_data == CMD_RUN) begin
          state_d   = S_RUN;
          pipe_en_d = 1'b1;
        end else if (i_rx_valid && i_rx_data == CMD_NEXT) begin
          pipe_en_d = 1'b1;
        end
      end
      S_DONE: begin
        if (i_rx_valid && is_run_or_step) begin
          state_d     = S_PIPE_RST;
          mode_step_d = (i_rx_data == CMD_STEP);
          pipe_rst_d  = 1'b0;
          cycle_cnt_d = '0;
          done_d      = 1'b0;
        end else if (i_rx_valid && i_rx_data == CMD_LOAD) begin
          state_d    = S_LOAD;
          addr_d     = '0;
          byte_cnt_d = '0;
          loaded_d   = 1'b0;
          done_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The counter advances together with every enable cycle it reports.
    if (pipe_en_d) cycle_cnt_d = cycle_cnt_q + LEN'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      mode_step_q <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_data_q   <= '0;
      pipe_en_q   <= 1'b0;
      pipe_rst_q  <= 1'b1;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      mode_step_q <= mode_step_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_data_q   <= im_data_d;
      pipe_en_q   <= pipe_en_d;
      pipe_rst_q  <= pipe_rst_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign o_im_we     = im_we_q;
  assign o_im_addr   = im_addr_q;
  assign o_im_data   = im_data_q;
  assign o_pipe_en   = pipe_en_q;
  assign o_pipe_rst  = pipe_rst_q;
  assign o_loaded    = loaded_q;
  assign o_done      = done_q;
  assign o_word_cnt  = word_cnt_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_im_debug_sequencer.sv
// Self-checking bench for im_debug_sequencer with a 4-word memory so the
// full-memory path is reachable; expected writes and counts come from a model.
module tb_im_debug_sequencer;

  localparam int LEN   = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int SB_W  = AW + LEN;
  localparam logic [7:0]     B_L = 8'h4C;
  localparam logic [7:0]     B_R = 8'h52;
  localparam logic [7:0]     B_S = 8'h53;
  localparam logic [7:0]     B_N = 8'h4E;
  localparam logic [LEN-1:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [2:0]     ST_IDLE = 3'd0;
  localparam logic [2:0]     ST_STEP = 3'd5;
  localparam logic [2:0]     ST_DONE = 3'd6;

  logic          clk, rst_n, rx_valid, halt;
  logic [7:0]    rx_data;
  logic          o_im_we, o_pipe_en, o_pipe_rst, o_loaded, o_done;
  logic [AW-1:0] o_im_addr;
  logic [LEN-1:0] o_im_data, o_cycle_cnt;
  logic [AW:0]   o_word_cnt;
  logic [2:0]    o_dbg_state;

  im_debug_sequencer #(.LEN(LEN), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_halt(halt), .o_im_we(o_im_we), .o_im_addr(o_im_addr), .o_im_data(o_im_data),
    .o_pipe_en(o_pipe_en), .o_pipe_rst(o_pipe_rst), .o_loaded(o_loaded),
    .o_done(o_done), .o_word_cnt(o_word_cnt), .o_cycle_cnt(o_cycle_cnt),
    .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] obs_q[$];
  int obs_rd = 0;
  logic [LEN-1:0] prog_q[$];
  int exp_words = 0;
  int en_cycles = 0, en_pulses = 0, rst_cycles = 0;
  logic en_prev = 1'b0;
  int r0, e0, p0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor samples just after each rising edge
  always @(posedge clk) begin
    #1;
    if (o_im_we) obs_q.push_back({o_im_addr, o_im_data});
    if (o_pipe_en) en_cycles++;
    if (o_pipe_en && !en_prev) en_pulses++;
    if (!o_pipe_rst) rst_cycles++;
    en_prev = o_pipe_en;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks; callers are always positioned at a falling edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [LEN-1:0] rand_word();
    logic [LEN-1:0] w;
    w = $urandom();
    if (w == HALT_W) w = '0;
    return w;
  endfunction

  // Scoreboard: every observed write against the model's expected list
  task automatic compare_writes();
    logic [SB_W-1:0] e;
    check("wr_count", 64'(obs_q.size() - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      check("wr_addr_data", 64'(obs_q[obs_rd]), 64'(e));
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  // Model: words are stored from address 0 until the terminator or a full memory
  task automatic load_prog(input int gap_max);
    int n;
    bit ended;
    logic [AW-1:0] a;
    n = 0;
    ended = 0;
    foreach (prog_q[i]) begin
      if (!ended) begin
        a = AW'(n);
        exp_q.push_back({a, prog_q[i]});
        n++;
        if (prog_q[i] == HALT_W || n == DEPTH) ended = 1;
      end
    end
    exp_words = n;
    send_byte(B_L);
    idle($urandom_range(0, gap_max));
    foreach (prog_q[i]) begin
      for (int b = 3; b >= 0; b--) begin
        send_byte(prog_q[i][8*b +: 8]);
        idle($urandom_range(0, gap_max));
      end
    end
    idle(3);
    compare_writes();
    check("loaded", 64'(o_loaded), 64'(1));
    check("word_cnt", 64'(o_word_cnt), 64'(exp_words));
    check("state_idle_after_load", 64'(o_dbg_state), 64'(ST_IDLE));
    check("done_after_load", 64'(o_done), 64'(0));
  endtask

  // Counts enabled cycles seen by the bench, raises halt on the n-th one
  task automatic run_then_halt(input int n, input int base);
    int seen;
    int budget;
    seen = 0;
    budget = 300;
    while (seen < n && budget > 0) begin
      if (o_pipe_en) seen++;
      if (seen < n) begin
        @(negedge clk);
        budget--;
      end
    end
    check("run_enable_seen", 64'(seen), 64'(n));
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_pipe_en", 64'(o_pipe_en), 64'(0));
    check("halt_done", 64'(o_done), 64'(1));
    check("halt_cycle_cnt", 64'(o_cycle_cnt), 64'(base + n));
    check("halt_state", 64'(o_dbg_state), 64'(ST_DONE));
  endtask

  task automatic snapshot();
    r0 = rst_cycles;
    e0 = en_cycles;
    p0 = en_pulses;
  endtask

  initial begin
    int k, nn, len;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    halt = 1'b0;
    #23;
    check("rst_pipe_en", 64'(o_pipe_en), 64'(0));
    check("rst_pipe_rst", 64'(o_pipe_rst), 64'(1));
    check("rst_loaded", 64'(o_loaded), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_im_we", 64'(o_im_we), 64'(0));
    check("rst_word_cnt", 64'(o_word_cnt), 64'(0));
    check("rst_cycle_cnt", 64'(o_cycle_cnt), 64'(0));
    check("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Run/step before any load are ignored
    snapshot();
    send_byte(B_R);
    send_byte(B_S);
    idle(4);
    check("gate_no_pipe_rst", 64'(rst_cycles - r0), 64'(0));
    check("gate_no_pipe_en", 64'(en_cycles - e0), 64'(0));
    check("gate_state", 64'(o_dbg_state), 64'(ST_IDLE));

    // Directed load
    prog_q = '{32'h0000_0001, 32'h0000_0002, HALT_W};
    load_prog(2);

    // Continuous run, halt after 10 enabled cycles
    snapshot();
    send_byte(B_R);
    check("run_pipe_rst_low", 64'(o_pipe_rst), 64'(0));
    run_then_halt(10, 0);
    check("run_one_reset", 64'(rst_cycles - r0), 64'(1));
    check("run_en_cycles", 64'(en_cycles - e0), 64'(10));

    // Step mode: three single-cycle pulses, then continue without a reset
    snapshot();
    send_byte(B_S);
    idle(1);
    check("step_state", 64'(o_dbg_state), 64'(ST_STEP));
    check("step_done_clear", 64'(o_done), 64'(0));
    for (int i = 0; i < 3; i++) begin
      send_byte(B_N);
      idle($urandom_range(1, 3));
    end
    check("step_en_cycles", 64'(en_cycles - e0), 64'(3));
    check("step_en_pulses", 64'(en_pulses - p0), 64'(3));
    check("step_cycle_cnt", 64'(o_cycle_cnt), 64'(3));
    check("step_one_reset", 64'(rst_cycles - r0), 64'(1));
    snapshot();
    send_byte(B_R);
    k = $urandom_range(3, 8);
    run_then_halt(k, 3);
    check("step_to_run_no_reset", 64'(rst_cycles - r0), 64'(0));

    // Halt coincident with NEXT: no pulse
    send_byte(B_S);
    idle(2);
    snapshot();
    halt = 1'b1;
    send_byte(B_N);
    halt = 1'b0;
    idle(2);
    check("halt_next_no_pulse", 64'(en_cycles - e0), 64'(0));
    check("halt_next_done", 64'(o_done), 64'(1));
    check("halt_next_state", 64'(o_dbg_state), 64'(ST_DONE));
    check("halt_next_cycle_cnt", 64'(o_cycle_cnt), 64'(0));

    // Back-to-back bytes, including one during each write cycle (load from DONE)
    prog_q = '{rand_word(), rand_word(), HALT_W};
    load_prog(0);

    // Full memory with no terminator; the trailing word must be ignored
    prog_q = '{rand_word(), rand_word(), rand_word(), rand_word(), 32'h1122_3344};
    load_prog(0);

    // Randomized programs and run modes
    for (int it = 0; it < 4; it++) begin
      prog_q.delete();
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) prog_q.push_back(rand_word());
      if (len < DEPTH || $urandom_range(0, 1) == 1) prog_q[len-1] = HALT_W;
      load_prog(2);
      snapshot();
      if ($urandom_range(0, 1) == 1) begin
        nn = $urandom_range(0, 4);
        send_byte(B_S);
        idle(1);
        for (int i = 0; i < nn; i++) begin
          send_byte(B_N);
          idle($urandom_range(1, 2));
        end
        check("rnd_step_pulses", 64'(en_pulses - p0), 64'(nn));
        send_byte(B_R);
      end else begin
        nn = 0;
        send_byte(B_R);
      end
      run_then_halt($urandom_range(1, 12), nn);
      check("rnd_one_reset", 64'(rst_cycles - r0), 64'(1));
    end

    // Asynchronous reset during RUN
    send_byte(B_R);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_run_pipe_en", 64'(o_pipe_en), 64'(0));
    check("arst_run_loaded", 64'(o_loaded), 64'(0));
    check("arst_run_pipe_rst", 64'(o_pipe_rst), 64'(1));
    check("arst_run_state", 64'(o_dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    snapshot();
    send_byte(B_R);
    idle(3);
    check("arst_run_gate", 64'(rst_cycles - r0), 64'(0));

    // Asynchronous reset after load byte 2, then reload from address 0
    send_byte(B_L);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 rst_n = 1'b0;
    #1;
    check("arst_load_state", 64'(o_dbg_state), 64'(ST_IDLE));
    check("arst_load_loaded", 64'(o_loaded), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    prog_q = '{rand_word(), HALT_W};
    load_prog(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/im_debug_sequencer.md
Name: im_debug_sequencer

Overview:
Controls the instruction fetch stage and the instruction memory write port from a byte stream delivered by a UART receiver. It first loads a program word-by-word into instruction memory. It then starts the pipeline in continuous mode or single-step mode, and stops it when the pipeline reports a halt. It sits between the UART receiver and the fetch/PC enable and reset inputs, and drives the memory write port that is otherwise tied off.

Parameters:
LEN, 32, instruction/data word width
ADDR_W, 11, instruction memory address width (depth 2**ADDR_W = 2048)
CMD_LOAD, 8'h4C, byte that starts a program load ('L')
CMD_RUN, 8'h52, byte that starts continuous execution ('R')
CMD_STEP, 8'h53, byte that enters step mode ('S')
CMD_NEXT, 8'h4E, byte that advances one cycle in step mode ('N')
HALT_WORD, 32'hFFFFFFFF, program terminator word; it is written to memory, then loading ends

Ports:
i_clk  in  1  system clock; all logic is on the rising edge
i_rst  in  1  asynchronous, active-low reset
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new byte
i_rx_data  in  8  received byte
i_halt  in  1  pipeline reached halt instruction; level, sampled each cycle
o_im_we  out  1  instruction memory write enable, one-cycle pulse
o_im_addr  out  ADDR_W  instruction memory write address (word index)
o_im_data  out  LEN  instruction memory write data
o_pipe_en  out  1  enable for PC/fetch and downstream stages
o_pipe_rst  out  1  active-low pipeline reset, one-cycle low pulse
o_loaded  out  1  valid program present in memory
o_done  out  1  execution finished (halt seen)
o_word_cnt  out  ADDR_W+1  number of words written in the last load
o_cycle_cnt  out  LEN  number of enabled cycles since the last pipeline reset

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE. All outputs are 0 except o_pipe_rst, which is 1. Word shift register, byte counter and address counter are cleared. Memory contents are not touched, but o_loaded is cleared. Reset mid-load or mid-run aborts immediately.
- States: IDLE, LOAD, WRITE, PIPE_RST, RUN, STEP, DONE.
- Bytes not listed for the current state are ignored, with no side effects.
- IDLE:
  - CMD_LOAD: go to LOAD. Clear address counter, byte counter and o_loaded.
  - CMD_RUN or CMD_STEP with o_loaded=1: go to PIPE_RST and remember the requested mode. Same bytes with o_loaded=0 are ignored.
- LOAD: each i_rx_valid shifts i_rx_data into the word register MSB-first (word = {word[23:0], byte}) and increments the byte counter. On the 4th byte, go to WRITE on the next edge.
- WRITE (exactly 1 cycle):
  - o_im_we=1, o_im_addr=address counter, o_im_data=assembled word.
  - The byte counter clears. The address counter increments. o_word_cnt = address counter + 1.
  - If word == HALT_WORD, or the address counter was 2**ADDR_W-1: go to IDLE with o_loaded=1.
  - Otherwise go to LOAD.
  - A byte strobed during WRITE is accepted as byte 0 of the next word; no byte is ever dropped.
- PIPE_RST (1 cycle): o_pipe_rst=0, o_pipe_en=0, o_cycle_cnt cleared to 0. Next state is RUN or STEP, per the remembered mode.
- RUN: o_pipe_en=1 every cycle and o_cycle_cnt increments each cycle. If i_halt=1 is sampled, go to DONE; o_pipe_en is 0 from that edge on.
- STEP:
  - o_pipe_en=0 by default.
  - CMD_NEXT: o_pipe_en=1 for exactly one cycle (the cycle after the strobe) and o_cycle_cnt increments by 1.
  - CMD_RUN: go to RUN without a pipeline reset.
  - i_halt=1: go to DONE. If a CMD_NEXT strobe coincides with i_halt=1, the halt wins and no pulse is issued.
- DONE:
  - o_done=1, o_pipe_en=0, o_cycle_cnt held.
  - CMD_RUN or CMD_STEP: go to PIPE_RST; o_done clears on leaving DONE.
  - CMD_LOAD: go to LOAD; o_loaded and o_done clear.
- o_cycle_cnt wraps modulo 2**LEN. o_word_cnt saturates at 2**ADDR_W.
- Latency from the i_rx_valid of the 4th byte to o_im_we=1 is 1 cycle. All outputs are registered.

Test Plan:
- Load: reset, then bytes L,00,00,00,01,00,00,00,02,FF,FF,FF,FF -> o_im_we pulses 3 times with (addr,data) = (0,0x00000001), (1,0x00000002), (2,0xFFFFFFFF); o_loaded=1; o_word_cnt=3; state IDLE.
- Run gating: 'R' before any load -> no o_pipe_rst pulse, o_pipe_en stays 0. After the load above, 'R' -> one cycle of o_pipe_rst=0, then o_pipe_en=1. Assert i_halt after 10 enabled cycles -> o_pipe_en=0 next edge, o_done=1, o_cycle_cnt=10.
- Step mode: after load, 'S' then 3×'N' -> exactly 3 single-cycle o_pipe_en pulses and o_cycle_cnt=3. 'R' then continues without an o_pipe_rst pulse.
- Boundary: the 4th byte strobes in the cycle before, then a byte strobes during WRITE -> both bytes are captured. Next word = {byte, next 3 bytes}. Halt coincident with 'N' -> no pulse, o_done=1.
- Full memory: with ADDR_W=2, load 4 words with no HALT_WORD -> after the 4th write the block returns to IDLE with o_loaded=1 and o_word_cnt=4. A 5th byte stream is ignored.
- Reset mid-operation: assert i_rst=0 during RUN and during LOAD byte 2 -> outputs return to reset values asynchronously (o_pipe_en=0, o_loaded=0, o_pipe_rst=1). The next 'L' starts again at address 0.
